// File: rtl/mips_mem_arb_pkg.sv
// Shared encodings for the MIPS memory arbiter: FSM states, port ids, default widths.
// Pure constants; no logic, no latency, no backpressure.
// States and port ids are plain 2-bit constants so legacy code can compare them directly.
package mips_mem_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    // FSM state enumeration
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    // Port-id encoding shared by the arbiter and its priority picker
    localparam logic [1:0] PORT_D    = 2'd0;
    localparam logic [1:0] PORT_I    = 2'd1;
    localparam logic [1:0] PORT_L    = 2'd2;
    localparam logic [1:0] PORT_NONE = 2'd3;

endpackage

// File: rtl/mips_arb_prio.sv
// Priority picker: data > fetch > loader, fetch promoted over data when starved.
// Latency: purely combinational.
// Backpressure: none; reports PORT_NONE when nobody requests.
module mips_arb_prio
    import mips_mem_arb_pkg::*;
(
    input  logic       d_req,
    input  logic       i_req,
    input  logic       l_req,
    input  logic       starve,
    output logic [1:0] win_id
);

    always_comb begin
        win_id = PORT_NONE;
        if (starve && i_req) begin
            win_id = PORT_I;
        end else if (d_req) begin
            win_id = PORT_D;
        end else if (i_req) begin
            win_id = PORT_I;
        end else if (l_req) begin
            win_id = PORT_L;
        end
    end

endmodule

// File: rtl/mips_mem_arbiter.sv
// Serialises data, fetch and loader accesses onto one single-port synchronous SRAM.
// Latency: req to ack 2 cycles from IDLE; one access per 3 cycles.
// Backpressure: requesters hold req until ack; loader arbitrates only with MEM_ARB_LOADER_EN.
module mips_mem_arbiter
    import mips_mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_ack,
    output logic [DATA_W-1:0] l_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [1:0]        state;
    logic [1:0]        win;
    logic [1:0]        win_sel;
    logic              we_q;
    logic              l_ack_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [DATA_W-1:0] i_rdata_q;
    logic [DATA_W-1:0] l_rdata_q;
    logic [CNT_W-1:0]  starve_cnt;
    logic              starve;

    logic              l_req_eff;
    logic              l_we_eff;
    logic [ADDR_W-1:0] l_addr_eff;
    logic [DATA_W-1:0] l_wdata_eff;

`ifdef MEM_ARB_LOADER_EN
    assign l_req_eff   = l_req;
    assign l_we_eff    = l_we;
    assign l_addr_eff  = l_addr;
    assign l_wdata_eff = l_wdata;
    assign l_ack       = l_ack_q;
    assign l_rdata     = (state == RESP && win == PORT_L && !we_q) ? mem_rdata : l_rdata_q;
`else
    logic unused_loader;
    assign l_req_eff     = 1'b0;
    assign l_we_eff      = 1'b0;
    assign l_addr_eff    = '0;
    assign l_wdata_eff   = '0;
    assign l_ack         = 1'b0;
    assign l_rdata       = '0;
    assign unused_loader = ^{l_req, l_we, l_addr, l_wdata, l_ack_q, l_rdata_q};
`endif

    assign starve = (starve_cnt >= CNT_W'(STARVE_MAX));
    assign busy   = (state != IDLE);

    // Read data is forwarded straight from the SRAM during RESP so it lines up with ack
    assign d_rdata = (state == RESP && win == PORT_D && !we_q) ? mem_rdata : d_rdata_q;
    assign i_rdata = (state == RESP && win == PORT_I) ? mem_rdata : i_rdata_q;

    mips_arb_prio u_prio (
        .d_req  (d_req),
        .i_req  (i_req),
        .l_req  (l_req_eff),
        .starve (starve),
        .win_id (win_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            win        <= PORT_NONE;
            we_q       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            d_ack      <= 1'b0;
            i_ack      <= 1'b0;
            l_ack_q    <= 1'b0;
            d_rdata_q  <= '0;
            i_rdata_q  <= '0;
            l_rdata_q  <= '0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_sel != PORT_NONE) begin
                        state  <= ACCESS;
                        win    <= win_sel;
                        mem_en <= 1'b1;
                        case (win_sel)
                            PORT_D: begin
                                mem_addr  <= d_addr;
                                mem_we    <= d_we;
                                we_q      <= d_we;
                                mem_wdata <= d_wdata;
                            end
                            PORT_I: begin
                                mem_addr  <= i_addr;
                                mem_we    <= 1'b0;
                                we_q      <= 1'b0;
                                mem_wdata <= '0;
                            end
                            default: begin
                                mem_addr  <= l_addr_eff;
                                mem_we    <= l_we_eff;
                                we_q      <= l_we_eff;
                                mem_wdata <= l_wdata_eff;
                            end
                        endcase
                    end
                end
                ACCESS: begin
                    state   <= RESP;
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    d_ack   <= (win == PORT_D);
                    i_ack   <= (win == PORT_I);
                    l_ack_q <= (win == PORT_L);
                end
                RESP: begin
                    state   <= IDLE;
                    d_ack   <= 1'b0;
                    i_ack   <= 1'b0;
                    l_ack_q <= 1'b0;
                    if (!we_q) begin
                        case (win)
                            PORT_D:  d_rdata_q <= mem_rdata;
                            PORT_I:  i_rdata_q <= mem_rdata;
                            PORT_L:  l_rdata_q <= mem_rdata;
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase

            // Counts data grants that overtook a waiting fetch
            if (!i_req) begin
                starve_cnt <= '0;
            end else if (state == IDLE && win_sel == PORT_I) begin
                starve_cnt <= '0;
            end else if (state == IDLE && win_sel == PORT_D && !starve) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: directed scenarios, then random requesters checked
// against a transaction-level model (serial accesses, priority with starvation rule, word memory).
module tb_mips_mem_arbiter;

    localparam int AW   = 10;
    localparam int DW   = 32;
    localparam int SMAX = 4;
`ifdef MEM_ARB_LOADER_EN
    localparam bit LOADER_EN = 1'b1;
`else
    localparam bit LOADER_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          d_req, d_we, d_ack;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          i_req, i_ack;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          l_req, l_we, l_ack;
    logic [AW-1:0] l_addr;
    logic [DW-1:0] l_wdata, l_rdata;
    logic          mem_en, mem_we, busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    mips_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_ack(l_ack), .l_rdata(l_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous SRAM with a bench-side preload port
    logic [DW-1:0] sram [0:1023];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_dat;

    always @(posedge clk) begin
        if (pre_we) begin
            sram[pre_addr] <= pre_dat;
        end else if (mem_en) begin
            if (mem_we) sram[mem_addr] <= mem_wdata;
            else        mem_rdata      <= sram[mem_addr];
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_dat  = d;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic clear_reqs();
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        i_req = 0; i_addr = '0;
        l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
    endtask

    // Random-phase agents and model state
    int            pst [3];
    int            rate [3];
    logic          a_req [3];
    logic          a_we [3];
    logic [AW-1:0] a_addr [3];
    logic [DW-1:0] a_wd [3];
    logic [DW-1:0] ref_mem [0:31];
    logic [DW-1:0] last_rd [3];
    int            next_free, g_t, g_p, sc, gnt;
    logic          g_we, acked;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wd, g_rd;

    initial begin
        rst = 1'b1;
        pre_we = 1'b0; pre_addr = '0; pre_dat = '0;
        clear_reqs();
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_i_ack", 32'(i_ack), 32'd0);
        chk("rst_l_ack", 32'(l_ack), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_l_rdata", l_rdata, 32'd0);
        tick();
        rst = 1'b0;

        // Single fetch
        preload(10'h005, 32'h2801000A);
        i_req = 1; i_addr = 10'h005;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) i_req = 0;
            @(negedge clk);
            chk("fetch_ack", 32'(i_ack), 32'(c == 2));
            if (c == 1) begin
                chk("fetch_mem_en", 32'(mem_en), 32'd1);
                chk("fetch_mem_we", 32'(mem_we), 32'd0);
                chk("fetch_mem_addr", 32'(mem_addr), 32'h005);
            end
            if (c >= 2) chk("fetch_rdata", i_rdata, 32'h2801000A);
            chk("fetch_busy", 32'(busy), 32'(c == 1 || c == 2));
            tick();
        end

        // Simultaneous data write and fetch, then read back
        preload(10'h000, 32'h12345678);
        d_req = 1; d_we = 1; d_addr = 10'h3FF; d_wdata = 32'hDEADBEEF;
        i_req = 1; i_addr = 10'h000;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin d_req = 0; d_we = 0; end
            @(negedge clk);
            chk("both_d_ack", 32'(d_ack), 32'(c == 2));
            chk("both_i_ack", 32'(i_ack), 32'(c == 5));
            if (c == 1) begin
                chk("both_wr_we", 32'(mem_we), 32'd1);
                chk("both_wr_addr", 32'(mem_addr), 32'h3FF);
                chk("both_wr_data", mem_wdata, 32'hDEADBEEF);
            end
            if (c == 4) chk("both_fetch_we", 32'(mem_we), 32'd0);
            if (c == 5) chk("both_i_rdata", i_rdata, 32'h12345678);
            tick();
        end
        i_req = 0;
        d_req = 1; d_we = 0; d_addr = 10'h3FF;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) d_req = 0;
            @(negedge clk);
            chk("rdback_ack", 32'(d_ack), 32'(c == 2));
            if (c >= 2) chk("rdback_data", d_rdata, 32'hDEADBEEF);
            tick();
        end

        // Starvation: both held high, expect D,D,D,D,I,D
        d_req = 1; d_we = 0; d_addr = 10'h005; i_req = 1; i_addr = 10'h005;
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            chk("starve_d_ack", 32'(d_ack), 32'((c % 3 == 2) && (c / 3 != 4)));
            chk("starve_i_ack", 32'(i_ack), 32'((c % 3 == 2) && (c / 3 == 4)));
            tick();
        end
        clear_reqs();
        repeat (3) tick();

        // Reset during the ACCESS cycle of a data write
        d_req = 1; d_we = 1; d_addr = 10'h020; d_wdata = 32'hCAFEF00D;
        tick();
        rst = 1; d_req = 0; d_we = 0;
        @(negedge clk);
        chk("rstop_access_en", 32'(mem_en), 32'd1);
        tick();
        rst = 0;
        @(negedge clk);
        chk("rstop_busy", 32'(busy), 32'd0);
        chk("rstop_mem_en", 32'(mem_en), 32'd0);
        chk("rstop_d_rdata", d_rdata, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstop_no_ack", 32'(d_ack), 32'd0);
            chk("rstop_idle", 32'(busy), 32'd0);
            tick();
        end

        // Loader write
        preload(10'h010, 32'hFFFFFFFF);
        l_req = 1; l_we = 1; l_addr = 10'h010; l_wdata = 32'h00000001;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin l_req = 0; l_we = 0; end
            @(negedge clk);
            chk("ldr_ack", 32'(l_ack), 32'(LOADER_EN && c == 2));
            chk("ldr_mem_en", 32'(mem_en), 32'(LOADER_EN && c == 1));
            chk("ldr_rdata", l_rdata, 32'd0);
            tick();
        end
        chk("ldr_sram16", sram[16], LOADER_EN ? 32'h00000001 : 32'hFFFFFFFF);

        // Random phase
        clear_reqs();
        rst = 1;
        repeat (2) tick();
        rst = 0;
        for (int k = 0; k < 32; k++) begin
            ref_mem[k] = $urandom;
            preload(AW'(k), ref_mem[k]);
        end
        rate[0] = 50; rate[1] = 40; rate[2] = 30;
        for (int p = 0; p < 3; p++) begin
            pst[p] = 0; a_req[p] = 0; a_we[p] = 0; a_addr[p] = '0; a_wd[p] = '0;
            last_rd[p] = '0;
        end
        next_free = 0; g_t = -100; g_p = 0; sc = 0;
        g_we = 0; g_addr = '0; g_wd = '0; g_rd = '0;

        for (int t = 0; t < 1500; t++) begin
            for (int p = 0; p < 3; p++) begin
                if (pst[p] == 2) begin
                    if (t == g_t + 1 && $urandom_range(0, 9) == 0) a_req[p] = 0;
                end else if (pst[p] == 0) begin
                    if ($urandom_range(0, 99) < rate[p]) begin
                        a_req[p]  = 1;
                        a_we[p]   = (p == 1) ? 1'b0 : 1'($urandom_range(0, 1));
                        a_addr[p] = AW'($urandom_range(0, 31));
                        a_wd[p]   = $urandom;
                        pst[p]    = 1;
                    end else begin
                        a_req[p] = 0;
                    end
                end
            end
            d_req = a_req[0]; d_we = a_we[0]; d_addr = a_addr[0]; d_wdata = a_wd[0];
            i_req = a_req[1]; i_addr = a_addr[1];
            l_req = a_req[2]; l_we = a_we[2]; l_addr = a_addr[2]; l_wdata = a_wd[2];

            gnt = -1;
            if (t >= next_free) begin
                if (sc >= SMAX && a_req[1])      gnt = 1;
                else if (a_req[0])               gnt = 0;
                else if (a_req[1])               gnt = 1;
                else if (a_req[2] && LOADER_EN)  gnt = 2;
            end
            if (gnt >= 0) begin
                g_t = t; g_p = gnt; g_we = a_we[gnt]; g_addr = a_addr[gnt]; g_wd = a_wd[gnt];
                pst[gnt] = 2;
                next_free = t + 3;
                if (g_we) ref_mem[g_addr[4:0]] = g_wd;
                else      g_rd = ref_mem[g_addr[4:0]];
            end
            if (!a_req[1])     sc = 0;
            else if (gnt == 1) sc = 0;
            else if (gnt == 0) sc++;

            @(negedge clk);
            acked = (t == g_t + 2);
            if (acked && !g_we) last_rd[g_p] = g_rd;
            chk("rnd_d_ack", 32'(d_ack), 32'(acked && g_p == 0));
            chk("rnd_i_ack", 32'(i_ack), 32'(acked && g_p == 1));
            chk("rnd_l_ack", 32'(l_ack), 32'(acked && g_p == 2));
            chk("rnd_busy", 32'(busy), 32'(t == g_t + 1 || acked));
            chk("rnd_mem_en", 32'(mem_en), 32'(t == g_t + 1));
            if (t == g_t + 1) begin
                chk("rnd_mem_we", 32'(mem_we), 32'(g_we));
                chk("rnd_mem_addr", 32'(mem_addr), 32'(g_addr));
                if (g_we) chk("rnd_mem_wdata", mem_wdata, g_wd);
            end
            chk("rnd_d_rdata", d_rdata, last_rd[0]);
            chk("rnd_i_rdata", i_rdata, last_rd[1]);
            chk("rnd_l_rdata", l_rdata, last_rd[2]);
            if (acked) pst[g_p] = 0;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word address width (1024 x 32 memory).
REQ-002 SHALL have parameter DATA_W, default 32, data word width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, consecutive data-port grants allowed while fetch waits.
REQ-004 SHALL have ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- d_req / d_we  in  1 / 1  MEM-stage data request and write enable.
- d_addr / d_wdata  in  ADDR_W / DATA_W  data-port address and write data.
- d_ack / d_rdata  out  1 / DATA_W  data-port completion pulse and read data.
- i_req / i_addr  in  1 / ADDR_W  IF-stage fetch request (read-only) and address.
- i_ack / i_rdata  out  1 / DATA_W  fetch completion pulse and instruction word.
- l_req / l_we  in  1 / 1  program-loader request and write enable.
- l_addr / l_wdata  in  ADDR_W / DATA_W  loader address and write data.
- l_ack / l_rdata  out  1 / DATA_W  loader completion pulse and read data.
- mem_en / mem_we  out  1 / 1  single-port synchronous SRAM enable and write enable.
- mem_addr / mem_wdata  out  ADDR_W / DATA_W  SRAM address and write data.
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after mem_en.
- busy  out  1  high in any state other than IDLE.

Function
REQ-005 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; only IDLE samples requests.
REQ-006 IDLE with at least one req in cycle N: SHALL latch winner, address, we, wdata; go ACCESS in N+1 with mem_en=1 and registered mem_addr/mem_we/mem_wdata.
REQ-007 RESP (N+2): SHALL pulse winner's ack for exactly one cycle; winner's rdata = mem_rdata for reads, unchanged for writes; mem_en=0.
REQ-008 Latency SHALL be req-to-ack 2 cycles from IDLE; peak throughput one access per 3 cycles.
REQ-009 Priority SHALL be data > fetch > loader, unless the starvation override (REQ-010) applies.
REQ-010 Starvation counter SHALL increment on each data grant while i_req=1, clear on fetch grant or i_req=0; at STARVE_MAX the next arbitration grants fetch over data.
REQ-011 Requester SHALL hold req/addr/we/wdata stable until ack; a req still high in the cycle after ack is treated as a new request.
REQ-012 A req dropped after grant SHALL NOT abort the access; ack still pulses.
REQ-013 Only one ack SHALL be high per cycle; acks SHALL be mutually exclusive.
REQ-014 Fetch port SHALL always drive mem_we=0.
REQ-015 rdata outputs SHALL hold their last value until that port's next read completes.

Reset
REQ-016 rst=1 SHALL force next-cycle state=IDLE, mem_en=0, mem_we=0, all acks=0, busy=0, starvation counter=0; mem_addr, mem_wdata and all rdata = 0.
REQ-017 rst mid-ACCESS or mid-RESP SHALL abort the access; no ack is issued for it; requester must re-request.

Configuration
REQ-018 Macro MEM_ARB_LOADER_EN defined: loader port SHALL arbitrate per REQ-009.
REQ-019 MEM_ARB_LOADER_EN undefined: loader ports SHALL remain present, l_req/l_we/l_addr/l_wdata SHALL be ignored, l_ack=0 and l_rdata=0 constantly.

Structure
REQ-020 Package mips_mem_arb_pkg SHALL hold the FSM state enum (IDLE, ACCESS, RESP), port-id encoding (PORT_D, PORT_I, PORT_L, PORT_NONE) and default ADDR_W/DATA_W constants.
REQ-021 SHALL instantiate one combinational sub-module mips_arb_prio: inputs are the three reqs and the starvation flag; output is the winning port id.

Verification
REQ-022 Single fetch: i_req=1, i_addr=10'h005, SRAM[5]=32'h2801000A -> i_ack high exactly 2 cycles later, i_rdata=32'h2801000A.
REQ-023 Simultaneous d_req (write 32'hDEADBEEF @ 10'h3FF) and i_req @ 10'h000 -> data acked first; fetch acked 3 cycles later; subsequent read of 10'h3FF returns 32'hDEADBEEF.
REQ-024 Starvation: d_req and i_req held high continuously, STARVE_MAX=4 -> grant sequence D,D,D,D,I,D,...
REQ-025 Reset mid-op: rst asserted in the ACCESS cycle of a data write -> no d_ack; busy=0 next cycle; FSM in IDLE.
REQ-026 Loader: l_req write 32'h00000001 @ 10'h010, no other reqs -> with MEM_ARB_LOADER_EN, l_ack after 2 cycles and SRAM[16]=1; without it, l_ack never asserts and mem_en stays 0.
